// File: rtl/axi_burst_write_master.sv
// AXI4 burst write master: streams a FIFO to memory as INCR bursts that never cross a 4KB page.
// Optional feature macro: AXI_WM_BRESP_ABORT_EN (abort the transfer on SLVERR/DECERR).
module axi_burst_write_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int MAX_BURST_BEATS    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     i_dst_addr,
    input  logic [31:0]                       i_total_len,
    output logic                              o_busy,
    output logic                              o_write_done,
    output logic                              o_write_err,
    input  logic                              i_fifo_empty,
    output logic                              o_fifo_rd_en,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     i_w_data,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                        m_axi_awlen,
    output logic [2:0]                        m_axi_awsize,
    output logic [1:0]                        m_axi_awburst,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wlast,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready
);
    localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~C_M_AXI_ADDR_WIDTH'(BYTES - 1);
`ifdef AXI_WM_BRESP_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

    state_t                          state;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr;
    logic [31:0]                     remaining;
    logic [8:0]                      beats;
    logic [8:0]                      beat_idx;
    logic                            awvalid;
    logic                            busy;
    logic                            done;
    logic                            err;

    logic [32:0]                     ceil_beats;
    logic [12:0]                     page_beats;
    logic [8:0]                      beats_calc;
    logic [31:0]                     burst_bytes;
    logic                            last_burst;
    logic [LB-1:0]                   rem_mod;
    logic [BYTES-1:0]                strb_mask;
    logic                            bresp_err;

    // Burst length is the tightest of: bytes left, burst cap, bytes left in the 4KB page.
    always_comb begin
        ceil_beats = ({1'b0, remaining} + 33'(BYTES - 1)) >> LB;
        page_beats = (13'd4096 - {1'b0, addr[11:0]}) >> LB;
        beats_calc = 9'(MAX_BURST_BEATS);
        if (ceil_beats < 33'(beats_calc)) beats_calc = ceil_beats[8:0];
        if (page_beats < 13'(beats_calc)) beats_calc = page_beats[8:0];
    end

    assign burst_bytes = 32'(beats) << LB;
    assign last_burst  = (remaining <= burst_bytes);
    assign rem_mod     = remaining[LB-1:0];
    assign bresp_err   = ABORT_EN && (m_axi_bresp == 2'b10 || m_axi_bresp == 2'b11);

    always_comb begin
        strb_mask = '0;
        for (int i = 0; i < BYTES; i++) strb_mask[i] = (i < int'(rem_mod));
    end

    // NOTE: the W/B handshake signals are decoded from registered state so they drop to 0 in the
    // same cycle reset clears the FSM, without an extra pipeline stage on the FIFO pop path.
    assign m_axi_wvalid  = (state == W) && !i_fifo_empty;
    assign m_axi_wlast   = (state == W) && (beat_idx == beats - 9'd1);
    assign m_axi_wdata   = i_w_data;
    assign m_axi_wstrb   = (m_axi_wlast && last_burst && rem_mod != '0) ? strb_mask : '1;
    assign o_fifo_rd_en  = m_axi_wvalid && m_axi_wready;
    assign m_axi_bready  = (state == B);

    assign m_axi_awaddr  = addr;
    assign m_axi_awlen   = 8'(beats - 9'd1);
    assign m_axi_awsize  = 3'(LB);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid;
    assign o_busy        = busy;
    assign o_write_done  = done;
    assign o_write_err   = err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            beats     <= '0;
            beat_idx  <= '0;
            awvalid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    addr      <= i_dst_addr & ADDR_MASK;
                    remaining <= i_total_len;
                    err       <= 1'b0;
                    done      <= (i_total_len == 32'd0);
                    if (i_total_len != 32'd0) begin
                        busy  <= 1'b1;
                        state <= AW;
                    end
                end
                // First AW cycle registers the beat count; awvalid follows one cycle later.
                AW: if (!awvalid) begin
                    beats   <= beats_calc;
                    awvalid <= 1'b1;
                end else if (m_axi_awready) begin
                    awvalid  <= 1'b0;
                    beat_idx <= '0;
                    state    <= W;
                end
                W: if (o_fifo_rd_en) begin
                    if (m_axi_wlast) state <= B;
                    else             beat_idx <= beat_idx + 9'd1;
                end
                B: if (m_axi_bvalid) begin
                    addr      <= addr + C_M_AXI_ADDR_WIDTH'(burst_bytes);
                    remaining <= last_burst ? 32'd0 : remaining - burst_bytes;
                    if (last_burst || bresp_err) begin
                        err   <= bresp_err;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= AW;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_write_master.sv
// Self-checking bench for axi_burst_write_master: acts as AXI slave and FIFO, compares against a
// burst-splitting reference model computed from byte arithmetic.
module tb_axi_burst_write_master;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [31:0] i_dst_addr;
    logic [31:0] i_total_len;
    logic        o_busy, o_write_done, o_write_err;
    logic        i_fifo_empty, o_fifo_rd_en;
    logic [31:0] i_w_data;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;

`ifdef AXI_WM_BRESP_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_aw_addr[$];
    logic [7:0]  exp_aw_len[$];
    logic [3:0]  exp_strb[$];
    bit          exp_last[$];
    logic [31:0] words[$];

    always #5 clk = ~clk;

    axi_burst_write_master dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_dst_addr(i_dst_addr),
        .i_total_len(i_total_len), .o_busy(o_busy), .o_write_done(o_write_done),
        .o_write_err(o_write_err), .i_fifo_empty(i_fifo_empty), .o_fifo_rd_en(o_fifo_rd_en),
        .i_w_data(i_w_data), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    // Split a transfer into bursts: min(beats needed, 16, beats left in the 4KB page).
    function automatic void build_model(input logic [31:0] addr, input logic [31:0] len,
                                        input bit bad_first);
        longint a, rem, bt, lim;
        bit fin;
        exp_aw_addr.delete(); exp_aw_len.delete(); exp_strb.delete(); exp_last.delete();
        a   = longint'(addr & 32'hFFFF_FFFC);
        rem = longint'(len);
        while (rem > 0) begin
            bt  = (rem + 3) / 4;
            if (bt > 16) bt = 16;
            lim = (4096 - (a % 4096)) / 4;
            if (bt > lim) bt = lim;
            exp_aw_addr.push_back(32'(a));
            exp_aw_len.push_back(8'(bt - 1));
            for (longint j = 0; j < bt; j++) begin
                fin = (rem <= 4 * bt) && (j == bt - 1);
                exp_last.push_back(j == bt - 1);
                exp_strb.push_back((fin && (rem % 4) != 0) ? 4'((1 << (rem % 4)) - 1) : 4'hF);
            end
            if (ABORT && bad_first) break;
            a  += 4 * bt;
            rem = (rem > 4 * bt) ? rem - 4 * bt : 0;
        end
    endfunction

    task automatic quiet_inputs();
        i_start = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; i_fifo_empty = 1'b1; i_w_data = '0;
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({o_busy, o_write_done, o_write_err, m_axi_awvalid, m_axi_wvalid, m_axi_wlast,
             m_axi_bready, o_fifo_rd_en} !== 8'h00) begin
            n_fail++;
            $display("FAIL %s: outputs busy/done/err/awv/wv/wlast/bready/rd_en = %b, want 00000000",
                     tag, {o_busy, o_write_done, o_write_err, m_axi_awvalid, m_axi_wvalid,
                           m_axi_wlast, m_axi_bready, o_fifo_rd_en});
        end
    endtask

    // Plays AXI slave and FIFO for one transfer and checks every handshake against the model.
    task automatic run_transfer(input logic [31:0] addr, input logic [31:0] len, input bit gaps,
                                input bit rand_rdy, input bit bad_first, input bit poke,
                                input int stop_beats);
        int aw_cnt = 0, head = 0, b_cnt = 0, nb;
        bit b_pend = 0, aw_wait = 0, finished = 0, exp_err;
        logic [31:0] h_addr = '0;
        logic [7:0]  h_len = '0;
        exp_err = ABORT && bad_first;
        build_model(addr, len, bad_first);
        nb = exp_strb.size();
        words.delete();
        for (int i = 0; i < nb; i++) words.push_back($urandom);
        @(negedge clk);
        i_start = 1'b1; i_dst_addr = addr; i_total_len = len;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            i_start = poke && cyc == 6;
            if (poke && cyc == 6) begin i_dst_addr = 32'h3000; i_total_len = 32'd4; end
            i_fifo_empty  = (head >= nb) || (gaps && (cyc % 2 == 1));
            i_w_data      = (head < nb) ? words[head] : 32'h0;
            m_axi_awready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_wready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_bvalid  = b_pend;
            m_axi_bresp   = (bad_first && b_cnt == 0) ? 2'b10 : 2'b00;
            #1;
            if (cyc == 0) begin
                n_checks++;
                if ({o_busy, o_write_done, m_axi_awvalid} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL start_state: busy/done/awvalid = %b, want 100",
                             {o_busy, o_write_done, m_axi_awvalid});
                end
            end
            if (cyc == 1) begin
                n_checks++;
                if (m_axi_awvalid !== 1'b1) begin
                    n_fail++; $display("FAIL awvalid_timing: got %b want 1", m_axi_awvalid);
                end
            end
            n_checks++;
            if (o_fifo_rd_en !== (m_axi_wvalid && m_axi_wready)) begin
                n_fail++;
                $display("FAIL fifo_rd_en: got %b want %b", o_fifo_rd_en, m_axi_wvalid && m_axi_wready);
            end
            if (m_axi_awvalid && aw_wait) begin
                n_checks++;
                if (m_axi_awaddr !== h_addr || m_axi_awlen !== h_len) begin
                    n_fail++;
                    $display("FAIL aw_stable: got %h/%0d want %h/%0d", m_axi_awaddr, m_axi_awlen, h_addr, h_len);
                end
            end
            aw_wait = m_axi_awvalid && !m_axi_awready;
            h_addr = m_axi_awaddr; h_len = m_axi_awlen;
            if (m_axi_awvalid && m_axi_awready) begin
                n_checks++;
                if (aw_cnt >= exp_aw_addr.size()) begin
                    n_fail++; $display("FAIL aw_extra: got burst %0d want %0d bursts", aw_cnt + 1, exp_aw_addr.size());
                end else if (m_axi_awaddr !== exp_aw_addr[aw_cnt] || m_axi_awlen !== exp_aw_len[aw_cnt] ||
                             m_axi_awsize !== 3'd2 || m_axi_awburst !== 2'b01) begin
                    n_fail++;
                    $display("FAIL aw_burst%0d: got addr %h len %0d size %0d burst %0d want addr %h len %0d size 2 burst 1",
                             aw_cnt, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
                             exp_aw_addr[aw_cnt], exp_aw_len[aw_cnt]);
                end
                aw_cnt++;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_pend = 1'b0;
                b_cnt++;
                if (b_cnt == exp_aw_addr.size()) finished = 1'b1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                n_checks++;
                if (head >= nb) begin
                    n_fail++; $display("FAIL w_extra: got beat %0d want %0d beats", head + 1, nb);
                end else if (m_axi_wdata !== words[head] || m_axi_wstrb !== exp_strb[head] ||
                             m_axi_wlast !== exp_last[head]) begin
                    n_fail++;
                    $display("FAIL w_beat%0d: got data %h strb %h last %b want data %h strb %h last %b",
                             head, m_axi_wdata, m_axi_wstrb, m_axi_wlast, words[head], exp_strb[head], exp_last[head]);
                end
                if (m_axi_wlast) b_pend = 1'b1;
                head++;
                if (stop_beats != 0 && head == stop_beats) return;
            end
        end
        if (!finished) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: got %0d of %0d B responses within cycle budget", b_cnt, exp_aw_addr.size());
        end else begin
            @(negedge clk);
            quiet_inputs();
            #1;
            n_checks++;
            if ({o_write_done, o_busy, o_write_err} !== {2'b10, exp_err} || aw_cnt != exp_aw_addr.size() || head != nb) begin
                n_fail++;
                $display("FAIL completion: got done/busy/err %b aw %0d beats %0d want %b aw %0d beats %0d",
                         {o_write_done, o_busy, o_write_err}, aw_cnt, head, {2'b10, exp_err},
                         exp_aw_addr.size(), nb);
            end
            @(negedge clk); #1;
            n_checks++;
            if (m_axi_awvalid !== 1'b0 || o_write_done !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_after: got awvalid %b done %b want 0 1", m_axi_awvalid, o_write_done);
            end
        end
        quiet_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        quiet_inputs();
        i_fifo_empty = 1'b0;
        m_axi_wready = 1'b1;
        i_dst_addr = '0; i_total_len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_all_zero("reset_state");
        @(negedge clk);
        reset = 1'b0;
        quiet_inputs();
    endtask

    task automatic test_single_burst();
        run_transfer(32'h1000, 32'd64, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_4k_boundary();
        run_transfer(32'h0FF8, 32'd32, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_partial_strobe();
        run_transfer(32'h2000, 32'd10, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_fifo_gaps();
        run_transfer(32'h1000, 32'd64, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++)
            run_transfer(32'($urandom_range(0, 32'h3FFF)), 32'($urandom_range(1, 400)),
                         1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'($urandom_range(0, 1)), 0);
    endtask

    task automatic test_bresp();
        run_transfer(32'h4000, 32'd128, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        i_start = 1'b1; i_dst_addr = 32'h5000; i_total_len = 32'd0;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        n_checks++;
        if ({o_write_done, o_busy, m_axi_awvalid} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_len_done: got done/busy/awvalid %b want 100", {o_write_done, o_busy, m_axi_awvalid});
        end
        repeat (4) begin
            @(negedge clk); #1;
            n_checks++;
            if (m_axi_awvalid !== 1'b0 || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_len_quiet: got awvalid %b busy %b want 0 0", m_axi_awvalid, o_busy);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        run_transfer(32'h1000, 32'd64, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        reset = 1'b1;
        @(negedge clk); #1;
        check_all_zero("reset_mid_burst");
        reset = 1'b0;
        quiet_inputs();
        test_zero_len();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_4k_boundary();
        test_partial_strobe();
        test_fifo_gaps();
        test_back_to_back();
        test_bresp();
        test_zero_len();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_burst_write_master.md
AXI_BURST_WRITE_MASTER -- requirements
Module: axi_burst_write_master

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameters SHALL be, one per line:
  C_M_AXI_ADDR_WIDTH, 32, AXI address width.
  C_M_AXI_DATA_WIDTH, 32, data width; one of 32/64/128; BYTES = C_M_AXI_DATA_WIDTH/8.
  MAX_BURST_BEATS, 16, maximum beats per burst; power of 2, 1..256.
REQ-003 Ports SHALL be, one per line:
  clk  in  1  system clock.
  reset  in  1  synchronous active-high reset.
  i_start  in  1  start pulse; sampled only in IDLE.
  i_dst_addr  in  C_M_AXI_ADDR_WIDTH  destination byte address.
  i_total_len  in  32  transfer length in bytes; any value, including non-multiples of BYTES.
  o_busy  out  1  high in every state except IDLE.
  o_write_done  out  1  completion flag.
  o_write_err  out  1  error flag.
  i_fifo_empty  in  1  FIFO empty.
  o_fifo_rd_en  out  1  FIFO pop.
  i_w_data  in  C_M_AXI_DATA_WIDTH  FIFO head word, first-word-fall-through.
  m_axi_aw{addr,len,size,burst,valid}, m_axi_awready  AXI4 AW channel.
  m_axi_w{data,strb,last,valid}, m_axi_wready  AXI4 W channel.
  m_axi_bresp, m_axi_bvalid, m_axi_bready  AXI4 B channel.

Function
REQ-004 States SHALL be IDLE, AW, W, B.
  - IDLE->AW on i_start with nonzero length.
  - AW->W on AW handshake.
  - W->B on the handshake of the beat carrying WLAST.
  - B->AW on B handshake when bytes remain.
  - B->IDLE on B handshake when no bytes remain.
REQ-005 On accepted i_start:
  - Latch address with its low log2(BYTES) bits forced to 0.
  - Latch remaining bytes = i_total_len.
  - Clear o_write_done and o_write_err.
REQ-006 Burst beats SHALL equal the minimum of three values; awlen = beats-1:
  - ceil(remaining/BYTES);
  - MAX_BURST_BEATS;
  - (4096 - addr[11:0])/BYTES.
  Beat count is computed in an AW-entry cycle and registered before awvalid asserts.
REQ-007 AW channel:
  - awsize = log2(BYTES); awburst = INCR.
  - awvalid asserts on the cycle after entering AW, and holds with stable addr/len until awready.
REQ-008 W channel:
  - wvalid = (state==W) && !i_fifo_empty.
  - wdata = i_w_data.
  - o_fifo_rd_en = wvalid && wready.
  - wlast is asserted on beat index beats-1 only.
REQ-009 wstrb SHALL be all ones, except on the final beat of the whole transfer when remaining mod BYTES != 0: then the low (remaining mod BYTES) bits are 1 and the rest 0.
REQ-010 bready SHALL equal (state==B). On B handshake:
  - addr += beats*BYTES;
  - remaining -= min(remaining, beats*BYTES), saturating at 0.
REQ-011 Transfer end:
  - o_write_done SHALL assert on the cycle after the final B handshake.
  - It holds until the next accepted i_start.
REQ-012 i_start with i_total_len==0 SHALL:
  - set o_write_done next cycle;
  - stay in IDLE;
  - issue no AXI traffic.
REQ-013 i_start outside IDLE SHALL be ignored.
REQ-014 FIFO going empty mid-burst SHALL deassert wvalid without losing beat count; no timeout.

Reset
REQ-015 While reset is high at a clk edge, the following SHALL be 0: state=IDLE, all counters, awvalid, o_busy, o_write_done, o_write_err.
REQ-016 Combinational outputs follow: wvalid=0, wlast=0, bready=0, o_fifo_rd_en=0.
REQ-017 Reset mid-burst SHALL abandon the transfer immediately; no completion of the outstanding AXI burst is attempted.

Configuration
REQ-018 Macro AXI_WM_BRESP_ABORT_EN, when defined:
  - bresp of SLVERR or DECERR on any burst sets o_write_err and o_write_done the next cycle.
  - The block returns to IDLE without issuing remaining bursts.
REQ-019 Macro AXI_WM_BRESP_ABORT_EN, when undefined:
  - bresp is ignored and o_write_err is tied 0.
  - All bursts are always issued.

Verification (C_M_AXI_DATA_WIDTH=32, MAX_BURST_BEATS=16 unless stated)
REQ-020 addr 0x1000, len 64 -> one burst awlen=15; 16 beats wstrb=0xF; wlast on beat 16; done after B.
REQ-021 addr 0x0FF8, len 32 -> burst1 0x0FF8 awlen=1; burst2 0x1000 awlen=5; no 4KB crossing.
REQ-022 addr 0x2000, len 10 -> awlen=2; strobes 0xF, 0xF, 0x3; done.
REQ-023 i_fifo_empty toggled every other cycle, len 64 -> wvalid gated by empty; exactly 16 pops; data order preserved.
REQ-024 AXI_WM_BRESP_ABORT_EN defined, len 128, first bresp=2'b10 -> o_write_err=1 and done; only one AW issued.
REQ-025 Reset asserted during W beat 5, then i_start with len 0 -> all outputs 0 after reset; done next cycle with no AW.
